// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage; holds the pipeline via stallreq_for_ex.
// Define DIV_SIGNED_EN to honour div_signed (DIV); otherwise every divide is unsigned (DIVU).
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_annul,
    output logic             stallreq_for_ex,
    output logic             div_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] dvd_raw;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    // One restoring step; the extra top bit keeps divisors above 2^(WIDTH-1) exact.
    always_comb begin
        shifted = {rem_r, quo_r[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_r};
        if (diff[WIDTH]) begin
            rem_nx = shifted[WIDTH-1:0];
            quo_nx = {quo_r[WIDTH-2:0], 1'b0};
        end else begin
            rem_nx = diff[WIDTH-1:0];
            quo_nx = {quo_r[WIDTH-2:0], 1'b1};
        end
    end

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
    logic neg_dvd;
    logic neg_dvs;

    assign neg_dvd = div_signed & dividend[WIDTH-1];
    assign neg_dvs = div_signed & divisor[WIDTH-1];
    assign dvd_mag = neg_dvd ? -dividend : dividend;
    assign dvs_mag = neg_dvs ? -divisor : divisor;
    assign q_fin   = neg_q ? -quo_nx : quo_nx;
    assign r_fin   = neg_r ? -rem_nx : rem_nx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (!div_annul && state == IDLE && div_start) begin
            neg_q <= neg_dvd ^ neg_dvs;
            neg_r <= neg_dvd;
        end
    end
`else
    logic unused_div_signed;

    assign unused_div_signed = div_signed;
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign q_fin   = quo_nx;
    assign r_fin   = rem_nx;
`endif

    assign stallreq_for_ex = resetn & div_start & ~div_ready & ~div_annul;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            dvs_r     <= '0;
            dvd_raw   <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_ready <= 1'b0;
            busy      <= 1'b0;
        end else if (div_annul) begin
            state     <= IDLE;
            div_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_start) begin
                        dvd_raw <= dividend;
                        dvs_r   <= dvs_mag;
                        quo_r   <= dvd_mag;
                        rem_r   <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= (divisor == '0) ? DIVZERO : BUSY;
                    end
                end
                DIVZERO: begin
                    quotient  <= '1;
                    remainder <= dvd_raw;
                    div_ready <= 1'b1;
                    state     <= DONE;
                end
                BUSY: begin
                    rem_r <= rem_nx;
                    quo_r <= quo_nx;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        quotient  <= q_fin;
                        remainder <= r_fin;
                        div_ready <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    div_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    div_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver queues hand-computed results, a negedge monitor checks each ready pulse.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_annul;
    logic        stallreq_for_ex;
    logic        div_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [63:0] sb[$];

    div_unit #(.WIDTH(32)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .div_start       (div_start),
        .div_signed      (div_signed),
        .dividend        (dividend),
        .divisor         (divisor),
        .div_annul       (div_annul),
        .stallreq_for_ex (stallreq_for_ex),
        .div_ready       (div_ready),
        .quotient        (quotient),
        .remainder       (remainder),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resetn === 1'b1 && div_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("quotient", quotient, e[63:32]);
                chk("remainder", remainder, e[31:0]);
            end
        end
    end

    // Called at a negedge; drives operands, waits 'pre' cycles to the accept cycle,
    // then follows the divide to its ready cycle. Returns at that negedge with start still high.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] eq, input logic [31:0] er,
                           input int lat, input int pre);
        int k;
        int drops;
        dividend   = a;
        divisor    = b;
        div_signed = s;
        div_start  = 1'b1;
        sb.push_back({eq, er});
        repeat (pre) @(negedge clk);
        #1;
        chk("stall_accept", stallreq_for_ex, 1'b1);
        chk("busy_accept", busy, 1'b0);
        drops = 0;
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (div_ready) break;
            if (!stallreq_for_ex) drops++;
        end
        chk("latency", k, lat);
        chk("stall_held", drops, 0);
        chk("stall_at_ready", stallreq_for_ex, 1'b0);
    endtask

    initial begin
        resetn     = 1'b0;
        div_start  = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd0;
        divisor    = 32'd0;
        div_annul  = 1'b0;
        #1;
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_ready", div_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_stall", stallreq_for_ex, 1'b0);
        div_start = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 0);
        div_start = 1'b0;
        @(negedge clk);
        #1 chk("idle_after_done", busy, 1'b0);

`ifdef DIV_SIGNED_EN
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
        div_start = 1'b0;
        @(negedge clk);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33, 0);
`else
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 33, 0);
        div_start = 1'b0;
        @(negedge clk);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 33, 0);
`endif
        div_start = 1'b0;
        @(negedge clk);

        run_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFE, 33, 0);
        div_start = 1'b0;
        @(negedge clk);

        run_div(32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 2, 0);
        div_start = 1'b0;
        @(negedge clk);

        // Annul in BUSY cycle 10; the aborted divide is never queued.
        dividend  = 32'd5000;
        divisor   = 32'd9;
        div_start = 1'b1;
        repeat (10) @(negedge clk);
        div_annul = 1'b1;
        #1 chk("stall_annul", stallreq_for_ex, 1'b0);
        @(negedge clk);
        div_annul = 1'b0;
        #1;
        chk("annul_busy", busy, 1'b0);
        chk("annul_ready", div_ready, 1'b0);
        chk("annul_q_kept", quotient, 32'hFFFF_FFFF);
        chk("annul_r_kept", remainder, 32'h0000_1234);
        run_div(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 33, 0);
        div_start = 1'b0;
        @(negedge clk);

        // Asynchronous reset in BUSY cycle 20, start still asserted.
        dividend  = 32'd9999;
        divisor   = 32'd7;
        div_start = 1'b1;
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid_rst_quotient", quotient, 32'd0);
        chk("mid_rst_remainder", remainder, 32'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", div_ready, 1'b0);
        chk("mid_rst_stall", stallreq_for_ex, 1'b0);
        div_start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33, 0);

        // Back-to-back: second operands appear during DONE and are accepted the next cycle.
        div_start = 1'b0;
        @(negedge clk);
        run_div(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 33, 0);
        run_div(32'd7, 32'd8, 1'b0, 32'd0, 32'd7, 33, 1);
        div_start = 1'b0;

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit radix-2 restoring divider in the EX stage. It is the requester side of the stall protocol: it raises `stallreq_for_ex` while a divide is in flight, so the pipeline controller issues the PC..EX stall pattern (`StallBus'b001111`). It produces quotient and remainder for the HI/LO write path.

## Interface
Parameters:
- `WIDTH`, 32: operand, quotient and remainder width.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `div_start` in 1: EX holds a divide instruction. Level signal, held high while the instruction sits in EX.
- `div_signed` in 1: 1 = signed divide (DIV), 0 = unsigned (DIVU).
- `dividend` in WIDTH: numerator, sampled on the accept edge.
- `divisor` in WIDTH: denominator, sampled on the accept edge.
- `div_annul` in 1: synchronous abort (flush/exception). Highest priority after reset.
- `stallreq_for_ex` out 1: `Stop` (1) while a result is pending; wired to the controller.
- `div_ready` out 1: quotient and remainder are valid this cycle.
- `quotient` out WIDTH: LO result.
- `remainder` out WIDTH: HI result.
- `busy` out 1: FSM is not in IDLE.

## Operation
- FSM states: IDLE, DIVZERO, BUSY, DONE.
- IDLE:
  - `div_start` with `divisor == 0` -> DIVZERO.
  - `div_start` with nonzero divisor -> BUSY. On this edge: latch operands, clear the iteration counter and the partial remainder.
- DIVZERO -> DONE. Results: `quotient = {WIDTH{1'b1}}`, `remainder = dividend`, for both signed and unsigned.
- BUSY:
  - Each cycle shift `{rem, quo}` left by 1.
  - Trial-subtract the divisor magnitude from the upper half. If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore.
  - The 5-bit counter increments each cycle. After the count-31 iteration -> DONE.
- DONE:
  - `div_ready = 1` for exactly one cycle, with the results held in registers.
  - Always -> IDLE next edge. EX/MEM samples the results on that edge because the stall is released.
- `stallreq_for_ex = div_start & ~div_ready & ~div_annul`. It is combinational from state, so it is already asserted in the accept cycle.
- `div_annul` in any state -> IDLE next edge. No DONE, `div_ready` stays 0, result registers unchanged.
- A start seen in DONE is ignored; the next divide can only reach EX after DONE, so it is accepted from IDLE.
- Outputs remain stable outside DONE, but are defined valid only when `div_ready = 1`.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `quotient = 0`, `remainder = 0`, `div_ready = 0`, `busy = 0`.
  - `stallreq_for_ex = 0` while `resetn = 0`, regardless of `div_start`.
- Nonzero divisor, accept in cycle 0:
  - Cycle 0: `stallreq_for_ex = 1`, `busy = 0`.
  - Cycles 1..32: BUSY.
  - Cycle 33: DONE, `div_ready = 1`, `stallreq_for_ex = 0`.
  - Cycle 34: IDLE.
- Divide by zero: accept in cycle 0, DIVZERO in cycle 1, DONE in cycle 2.
- Reset mid-operation: immediate return to the reset values, no partial result, no ready pulse.
- Back-to-back divides: the second is accepted in the first IDLE cycle after DONE, with no lost cycles.

## Configuration
- `DIV_SIGNED_EN` defined:
  - When `div_signed = 1`, operands are converted to magnitudes on accept.
  - On entry to DONE: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - `0x80000000 / 0xFFFFFFFF` gives quotient `0x80000000`, remainder 0.
- `DIV_SIGNED_EN` undefined:
  - `div_signed` is ignored; every divide is unsigned.
  - The sign-conversion logic is absent.

## Test plan
- Unsigned 100/7, start held high:
  - `stallreq_for_ex = 1` in cycles 0..32.
  - Cycle 33: `div_ready = 1`, `quotient = 14`, `remainder = 2`, stall low.
- Signed (macro on) -7/2: `quotient = 0xFFFFFFFD`, `remainder = 0xFFFFFFFF`. With the macro off, the same operands give `quotient = 0x7FFFFFFC`, `remainder = 1`.
- Divide by zero, dividend `0x1234`: `div_ready = 1` in cycle 2 with `quotient = 0xFFFFFFFF` and `remainder = 0x1234`.
- `div_annul` in cycle 10 of BUSY:
  - Cycle 11: IDLE, stall low, no ready pulse.
  - A new divide accepted in cycle 11 completes with correct results.
- `resetn` low in cycle 20 of BUSY: all outputs at reset values asynchronously; after release, 9/3 returns `quotient = 3`, `remainder = 0`.
- Back-to-back 50/5 then 7/8:
  - First `div_ready` in cycle 33 (10, 0).
  - Second accepted in cycle 34, `div_ready` in cycle 67 with 0, 7.
